alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/div_iter.sv | 64 ++++++
 rtl/alu_seq.sv | 221 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared types for the sequential ALU: opcode encoding, FSM
//               state encoding and bit positions inside the flags vector.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcode values 10..15 are illegal and are reported through err.
    typedef enum logic [3:0] {
        OP_SUM  = 4'd0,
        OP_REST = 4'd1,
        OP_MULT = 4'd2,
        OP_DIV  = 4'd3,
        OP_MOD  = 4'd4,
        OP_AND  = 4'd5,
        OP_OR   = 4'd6,
        OP_XOR  = 4'd7,
        OP_SHR  = 4'd8,
        OP_SHL  = 4'd9
    } op_t;

    // Width of the opcode field that carries the op_t encoding.
    localparam int c_opc_w = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    // flags = {NEG, ZERO, CARRY, OVF}
    localparam int c_flag_neg   = 3;
    localparam int c_flag_zero  = 2;
    localparam int c_flag_carry = 1;
    localparam int c_flag_ovf   = 0;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ============================================================================
// Module      : div_iter
// Description : Iterative restoring divider, one quotient bit per step.
//               load  - capture dividend/divisor, clear partial remainder
//               step  - commit one restoring-division step
//               quotient/remainder - values the divider holds once the step
//               currently being evaluated is committed, so the caller can
//               capture the final answer on the same edge as the last step.
// Ports       : clk, rst (sync, active-high), load, step, dividend[N],
//               divisor[N], quotient[N], remainder[N]
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         step,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder
);

    logic [N-1:0] r_quo;   // dividend shifts out the top, quotient bits in at the bottom
    logic [N-1:0] r_rem;
    logic [N-1:0] r_dsr;

    logic [N:0]   w_part;
    logic         w_ge;
    logic [N-1:0] w_rem_sub;
    logic [N-1:0] w_rem_n;
    logic [N-1:0] w_quo_n;

    // Partial remainder stays below the divisor, so the restored or reduced
    // value always fits back into N bits.
    assign w_part    = {r_rem, r_quo[N-1]};
    assign w_ge      = (w_part >= {1'b0, r_dsr});
    assign w_rem_sub = w_part[N-1:0] - r_dsr;
    assign w_rem_n   = w_ge ? w_rem_sub : w_part[N-1:0];
    assign w_quo_n   = {r_quo[N-2:0], w_ge};

    assign quotient  = w_quo_n;
    assign remainder = w_rem_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_quo <= '0;
            r_rem <= '0;
            r_dsr <= '0;
        end else if (load) begin
            r_quo <= dividend;
            r_rem <= '0;
            r_dsr <= divisor;
        end else if (step) begin
            r_quo <= w_quo_n;
            r_rem <= w_rem_n;
        end
    end

endmodule : div_iter
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq
// Description : Sequential ALU. Single-cycle ops complete one cycle after
//               acceptance; DIV/MOD with a non-zero divisor run N steps of
//               an iterative divider first. Results are registered on entry
//               to FINISH and held until the next completion.
// Ports       : clk, rst (sync, active-high), start, op[OPW], a[N], b[N]
//               -> busy, done (1-cycle pulse), result[N],
//                  flags[4] {NEG,ZERO,CARRY,OVF}, err
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_pkg::*;
#(
    parameter int N   = 4,
    parameter int OPW = 4     // must be at least c_opc_w
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [OPW-1:0] op,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [N-1:0]   result,
    output logic [3:0]     flags,
    output logic           err
);

    localparam int c_cnt_w = (N > 2) ? $clog2(N) : 1;

    state_t               r_state;
    state_t               w_state_n;
    logic                 w_capture;
    logic [N-1:0]         r_a;
    logic [N-1:0]         r_b;
    logic [OPW-1:0]       r_op;
    logic [c_cnt_w-1:0]   r_cnt;

    logic                 w_idle;
    logic                 w_accept;
    logic [N-1:0]         w_a;
    logic [N-1:0]         w_b;
    logic [OPW-1:0]       w_op;
    op_t                  w_opc;
    logic                 w_op_legal;
    logic                 w_is_div;

    logic [N:0]           w_sum;
    logic [N:0]           w_diff;
    logic [2*N-1:0]       w_prod;
    logic [2*N-1:0]       w_shl;
    logic [2*N-1:0]       w_shr;
    logic                 w_big_shift;
    logic [N-1:0]         w_div_q;
    logic [N-1:0]         w_div_r;

    logic [N-1:0]         w_res;
    logic                 w_carry;
    logic                 w_ovf;
    logic                 w_err;
    logic                 w_legal;
    logic [3:0]           w_flags;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle && start;

    // While idle the ALU evaluates the live inputs so single-cycle ops are
    // captured on the accept edge; afterwards it works on the latched copy.
    assign w_a  = w_idle ? a  : r_a;
    assign w_b  = w_idle ? b  : r_b;
    assign w_op = w_idle ? op : r_op;

    assign w_opc      = op_t'(w_op[c_opc_w-1:0]);
    assign w_op_legal = (w_op <= OPW'(OP_SHL));
    assign w_is_div   = (w_op == OPW'(OP_DIV)) || (w_op == OPW'(OP_MOD));

    assign w_sum       = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff      = {1'b0, w_a} - {1'b0, w_b};
    assign w_prod      = {{N{1'b0}}, w_a} * {{N{1'b0}}, w_b};
    assign w_shl       = {{N{1'b0}}, w_a} << w_b;
    assign w_shr       = {w_a, {N{1'b0}}} >> w_b;
    assign w_big_shift = (w_b >= N'(N));

    div_iter #(
        .N (N)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .load      (w_accept),
        .step      (r_state == ST_DIVIDE),
        .dividend  (a),
        .divisor   (b),
        .quotient  (w_div_q),
        .remainder (w_div_r)
    );

    // Operation result. For DIV/MOD with b != 0 this is only captured on the
    // final DIVIDE cycle, when the divider outputs hold the finished answer.
    always_comb begin
        w_res   = '0;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        w_err   = 1'b0;
        w_legal = w_op_legal;
        case (w_opc)
            OP_SUM: begin
                w_res   = w_sum[N-1:0];
                w_carry = w_sum[N];
                w_ovf   = (w_a[N-1] == w_b[N-1]) && (w_sum[N-1] != w_a[N-1]);
            end
            OP_REST: begin
                w_res   = w_diff[N-1:0];
                w_carry = w_diff[N];
                w_ovf   = (w_a[N-1] != w_b[N-1]) && (w_diff[N-1] != w_a[N-1]);
            end
            OP_MULT: begin
                w_res   = w_prod[N-1:0];
                w_carry = |w_prod[2*N-1:N];
            end
            OP_DIV: begin
                w_res = (w_b == '0) ? '1 : w_div_q;
                w_err = (w_b == '0);
            end
            OP_MOD: begin
                w_res = (w_b == '0) ? w_a : w_div_r;
                w_err = (w_b == '0);
            end
            OP_AND: w_res = w_a & w_b;
            OP_OR:  w_res = w_a | w_b;
            OP_XOR: w_res = w_a ^ w_b;
            OP_SHR: begin
                w_res   = w_big_shift ? '0  : w_shr[2*N-1:N];
                w_carry = w_big_shift ? |w_a : |w_shr[N-1:0];
            end
            OP_SHL: begin
                w_res   = w_big_shift ? '0  : w_shl[N-1:0];
                w_carry = w_big_shift ? |w_a : |w_shl[2*N-1:N];
            end
            default: w_legal = 1'b0;
        endcase

        w_flags = '0;
        if (w_legal) begin
            w_flags[c_flag_neg]   = w_res[N-1];
            w_flags[c_flag_zero]  = (w_res == '0);
            w_flags[c_flag_carry] = w_carry;
            w_flags[c_flag_ovf]   = w_ovf;
        end else begin
            w_res = '0;
            w_err = 1'b1;
        end
    end

    // FSM next state; w_capture marks every transition into FINISH.
    always_comb begin
        w_state_n = r_state;
        w_capture = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (w_is_div && (w_b != '0)) begin
                        w_state_n = ST_DIVIDE;
                    end else begin
                        w_state_n = ST_FINISH;
                        w_capture = 1'b1;
                    end
                end
            end
            ST_DIVIDE: begin
                if (r_cnt == c_cnt_w'(N - 1)) begin
                    w_state_n = ST_FINISH;
                    w_capture = 1'b1;
                end
            end
            ST_FINISH: w_state_n = ST_IDLE;
            default:   w_state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            result <= '0;
            flags  <= '0;
            err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a   <= a;
                r_b   <= b;
                r_op  <= op;
                r_cnt <= '0;
            end else if (r_state == ST_DIVIDE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_capture) begin
                result <= w_res;
                flags  <= w_flags;
                err    <= w_err;
            end
        end
    end

    assign busy = (r_state != ST_IDLE);
    assign done = (r_state == ST_FINISH);

endmodule : alu_seq
`default_nettype wire

// File: tb/tb_alu_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq
// Description : Directed self-checking bench for alu_seq with N=4, OPW=4.
//               Expected values are hand-computed constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq;

    localparam int N   = 4;
    localparam int OPW = 4;

    logic           clk;
    logic           rst;
    logic           start;
    logic [OPW-1:0] op;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           busy;
    logic           done;
    logic [N-1:0]   result;
    logic [3:0]     flags;
    logic           err;

    int n_chk;
    int n_bad;

    alu_seq #(
        .N   (N),
        .OPW (OPW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flags  (flags),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op, measure cycles from accept edge to done, check outputs
    // during done and that they hold (with done low) one cycle later.
    task automatic run_op(input string tag, input logic [3:0] o, input logic [3:0] av,
                          input logic [3:0] bv, input int exp_lat, input logic [3:0] exp_res,
                          input logic [3:0] exp_flg, input logic exp_err);
        int lat;
        start = 1'b1;
        op    = o;
        a     = av;
        b     = bv;
        tick();
        start = 1'b0;
        lat   = 1;
        while (!done && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, ".lat"},   lat,     exp_lat);
        chk({tag, ".busy"},  busy,    1);
        chk({tag, ".res"},   result,  exp_res);
        chk({tag, ".flags"}, flags,   exp_flg);
        chk({tag, ".err"},   err,     exp_err);
        tick();
        chk({tag, ".done_off"}, done, 0);
        chk({tag, ".hold"},     result, exp_res);
    endtask

    initial begin
        int pulses;
        int first;
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = '0;
        a     = '0;
        b     = '0;
        tick();
        tick();
        chk("rst.busy",   busy,   0);
        chk("rst.done",   done,   0);
        chk("rst.result", result, 0);
        chk("rst.flags",  flags,  0);
        chk("rst.err",    err,    0);
        rst = 1'b0;
        tick();

        //      tag      op     a      b      lat res    flags    err
        run_op("sum",   4'd0,  4'd9,  4'd8,  1,  4'd1,  4'b0011, 1'b0);
        run_op("div",   4'd3,  4'd13, 4'd4,  5,  4'd3,  4'b0000, 1'b0);
        run_op("mod",   4'd4,  4'd13, 4'd4,  5,  4'd1,  4'b0000, 1'b0);
        run_op("div0",  4'd3,  4'd7,  4'd0,  1,  4'd15, 4'b1000, 1'b1);
        run_op("mod0",  4'd4,  4'd5,  4'd0,  1,  4'd5,  4'b0000, 1'b1);
        run_op("mult",  4'd2,  4'd5,  4'd7,  1,  4'd3,  4'b0010, 1'b0);
        run_op("shl",   4'd9,  4'd9,  4'd1,  1,  4'd2,  4'b0010, 1'b0);
        run_op("illeg", 4'd12, 4'd9,  4'd3,  1,  4'd0,  4'b0000, 1'b1);
        run_op("rest",  4'd1,  4'd3,  4'd5,  1,  4'd14, 4'b1010, 1'b0);
        run_op("and",   4'd5,  4'd12, 4'd10, 1,  4'd8,  4'b1000, 1'b0);
        run_op("or",    4'd6,  4'd4,  4'd1,  1,  4'd5,  4'b0000, 1'b0);
        run_op("xor",   4'd7,  4'd5,  4'd5,  1,  4'd0,  4'b0100, 1'b0);
        run_op("shrbig",4'd8,  4'd9,  4'd4,  1,  4'd0,  4'b0110, 1'b0);
        run_op("shr",   4'd8,  4'd9,  4'd1,  1,  4'd4,  4'b0010, 1'b0);
        run_op("div15", 4'd3,  4'd15, 4'd1,  5,  4'd15, 4'b1000, 1'b0);

        // start while busy must be ignored
        start = 1'b1;
        op    = 4'd3;
        a     = 4'd13;
        b     = 4'd4;
        tick();
        start  = 1'b0;
        pulses = 0;
        first  = 0;
        for (int k = 1; k <= 10; k++) begin
            if (done) begin
                pulses++;
                if (first == 0) first = k;
            end
            start = (k == 1);
            if (k == 1) begin
                op = 4'd0;
                a  = 4'd9;
                b  = 4'd8;
            end
            tick();
        end
        chk("ign.first",  first,  5);
        chk("ign.pulses", pulses, 1);
        chk("ign.res",    result, 3);
        chk("ign.flags",  flags,  0);
        chk("ign.busy",   busy,   0);

        // leave err/result non-zero so the reset clear is observable
        run_op("pre",   4'd4,  4'd5,  4'd0,  1,  4'd5,  4'b0000, 1'b1);

        // reset during DIVIDE aborts without a done pulse
        start = 1'b1;
        op    = 4'd3;
        a     = 4'd13;
        b     = 4'd4;
        tick();
        start = 1'b0;
        chk("abort.busy_pre", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort.busy",   busy,   0);
        chk("abort.result", result, 0);
        chk("abort.flags",  flags,  0);
        chk("abort.err",    err,    0);
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            if (done) pulses++;
            tick();
        end
        chk("abort.pulses", pulses, 0);

        run_op("after", 4'd0,  4'd3,  4'd4,  1,  4'd7,  4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule : tb_alu_seq
`default_nettype wire
